// File: rtl/fifo_pkg.sv
// Shared FIFO helpers.
// Used by every FIFO flavour in the core.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFOs.
// Synchronous write, asynchronous read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WD    = 32,
  parameter int DEPTH = 8,
  localparam int AW   = ptr_w(DEPTH) - 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WD-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WD-1:0] o_rdata
);

  logic [WD-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy, level flags and sticky errors.
// Read port is show-ahead or registered, chosen at elaboration.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int WD     = 32,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 1,
  parameter bit FWFT   = 1'b1,
  localparam int PW    = ptr_w(DEPTH),
  localparam int AW    = PW - 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_write_en,
  input  logic [WD-1:0] i_data,
  input  logic          i_read_en,
  output logic [WD-1:0] o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic [PW-1:0] o_count,
  input  logic          i_clr_err,
  output logic          o_overflow,
  output logic          o_underflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_flags: DEPTH must be a power of two >= 2");
  end
  if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
    $error("fifo_sync_flags: AF_LVL out of range 1..DEPTH");
  end
  if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flags: AE_LVL out of range 0..DEPTH-1");
  end

  localparam logic [PW-1:0] ONE_C   = PW'(1);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LVL);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push, pop;
  logic [WD-1:0] rdata;

  always_comb begin
    push  = i_write_en && !full_q;
    pop   = i_read_en && !empty_q;
    wr_d  = push ? wr_q + ONE_C : wr_q;
    rd_d  = pop ? rd_q + ONE_C : rd_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE_C;
      2'b01:   cnt_d = cnt_q - ONE_C;
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
    af_d    = (cnt_d >= AF_C);
    ae_d    = (cnt_d <= AE_C);
    // a fresh error in the clear cycle must survive
    ovf_d   = (i_write_en && full_q) || (ovf_q && !i_clr_err);
    unf_d   = (i_read_en && empty_q) || (unf_q && !i_clr_err);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .WD    (WD),
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_q[AW-1:0]),
    .i_wdata (i_data),
    .i_raddr (rd_q[AW-1:0]),
    .o_rdata (rdata)
  );

  if (FWFT) begin : g_fwft
    assign o_data  = rdata;
    assign o_valid = !empty_q;
  end else begin : g_reg
    logic [WD-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    always_comb begin
      data_d  = data_q;
      valid_d = 1'b0;
      if (pop) begin
        data_d  = rdata;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
  end

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_count        = cnt_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Scoreboard bench for fifo_sync_flags.
// Show-ahead instance plus a registered-read instance.
module tb_fifo_sync_flags;

  localparam int WD = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          we = 0, re = 0, clr = 0;
  logic [WD-1:0] din = '0;
  logic [WD-1:0] dout;
  logic          valid, full, empty, afull, aempty, ovf, unf;
  logic [2:0]    count;

  logic          we2 = 0, re2 = 0, clr2 = 0;
  logic [WD-1:0] din2 = '0;
  logic [WD-1:0] dout2;
  logic          valid2, full2, empty2, afull2, aempty2, ovf2, unf2;
  logic [2:0]    count2;

  fifo_sync_flags #(
    .WD(WD), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_write_en(we), .i_data(din), .i_read_en(re),
    .o_data(dout), .o_valid(valid), .o_full(full), .o_empty(empty),
    .o_almost_full(afull), .o_almost_empty(aempty), .o_count(count),
    .i_clr_err(clr), .o_overflow(ovf), .o_underflow(unf)
  );

  fifo_sync_flags #(
    .WD(WD), .DEPTH(DEPTH), .AF_LVL(AF), .AE_LVL(AE), .FWFT(1'b0)
  ) u_reg (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_write_en(we2), .i_data(din2), .i_read_en(re2),
    .o_data(dout2), .o_valid(valid2), .o_full(full2), .o_empty(empty2),
    .o_almost_full(afull2), .o_almost_empty(aempty2), .o_count(count2),
    .i_clr_err(clr2), .o_overflow(ovf2), .o_underflow(unf2)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [WD-1:0] sb[$];
  int mcount = 0;
  logic movf = 0, munf = 0;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".count"}, 32'(count), 32'(mcount));
    check({tag, ".empty"}, 32'(empty), 32'(mcount == 0));
    check({tag, ".full"}, 32'(full), 32'(mcount == DEPTH));
    check({tag, ".afull"}, 32'(afull), 32'(mcount >= AF));
    check({tag, ".aempty"}, 32'(aempty), 32'(mcount <= AE));
    check({tag, ".valid"}, 32'(valid), 32'(mcount != 0));
    check({tag, ".ovf"}, 32'(ovf), 32'(movf));
    check({tag, ".unf"}, 32'(unf), 32'(munf));
  endtask

  task automatic cycle(input logic w, input logic [WD-1:0] d,
                       input logic r, input logic c, input string tag);
    logic p_ok, q_ok;
    logic [WD-1:0] exp;
    @(negedge clk);
    we = w; din = d; re = r; clr = c;
    #1;
    p_ok = w && (mcount < DEPTH);
    q_ok = r && (mcount > 0);
    if (q_ok) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s.sb: scoreboard underrun", tag);
      end else begin
        exp = sb.pop_front();
        check({tag, ".head_valid"}, 32'(valid), 32'd1);
        check({tag, ".data"}, 32'(dout), 32'(exp));
      end
    end
    if (p_ok) sb.push_back(d);
    movf = (w && mcount == DEPTH) || (movf && !c);
    munf = (r && mcount == 0) || (munf && !c);
    @(posedge clk);
    #1;
    mcount = mcount + int'(p_ok) - int'(q_ok);
    check_flags(tag);
  endtask

  initial begin
    #12;
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.aempty", 32'(aempty), 32'd1);
    check("rst.afull", 32'(afull), 32'd0);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.errs", {30'd0, ovf, unf}, 32'd0);
    check("rst.reg_data", 32'(dout2), 32'd0);
    check("rst.reg_valid", 32'(valid2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) cycle(1, 8'hA1 + 8'(i), 0, 0, "fill");
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, "drain");

    for (int i = 0; i < 4; i++) cycle(1, 8'hB1 + 8'(i), 0, 0, "fill2");
    cycle(1, 8'h55, 1, 0, "full_pp");
    cycle(0, 8'h00, 0, 1, "clr_ovf");
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, "drain2");

    cycle(1, 8'h0E, 0, 0, "pre_wrap");
    cycle(1, 8'h0F, 0, 0, "pre_wrap");
    for (int i = 0; i < 10; i++) cycle(1, 8'h10 + 8'(i), 1, 0, "wrap");
    cycle(0, 8'h00, 1, 0, "post_wrap");
    cycle(0, 8'h00, 1, 0, "post_wrap");

    cycle(1, 8'h77, 1, 0, "empty_pp");
    cycle(0, 8'h00, 1, 0, "empty_pop");
    cycle(0, 8'h00, 0, 1, "clr_unf");

    cycle(1, 8'hC1, 0, 0, "pre_rst");
    cycle(1, 8'hC2, 0, 0, "pre_rst");
    @(negedge clk);
    we = 0; re = 0; clr = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.empty", 32'(empty), 32'd1);
    check("mid_rst.count", 32'(count), 32'd0);
    check("mid_rst.valid", 32'(valid), 32'd0);
    sb.delete();
    mcount = 0;
    movf = 0;
    munf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 8'h00, 1, 0, "post_rst_pop");

    @(negedge clk);
    we2 = 1; din2 = 8'h3C;
    @(negedge clk);
    we2 = 0; re2 = 1;
    @(posedge clk);
    #1;
    check("reg.data", 32'(dout2), 32'h3C);
    check("reg.valid", 32'(valid2), 32'd1);
    @(negedge clk);
    re2 = 0;
    @(posedge clk);
    #1;
    check("reg.valid_drop", 32'(valid2), 32'd0);
    check("reg.data_hold", 32'(dout2), 32'h3C);
    check("reg.empty", 32'(empty2), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
